// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address-generation sequencer:
// FSM state encoding, the default transform size and a width-generic rotate-left.
package fft_pkg;

   localparam int LOG2N_DEF = 9;
   localparam int LOG2N_MAX = 12;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } agu_state_e;

   // Rotate the low `width` bits of val left by amt (amt < width); upper bits must be zero.
   function automatic logic [LOG2N_MAX-1:0] rotl(input logic [LOG2N_MAX-1:0] val,
                                                input int unsigned          amt,
                                                input int unsigned          width);
      logic [LOG2N_MAX-1:0] one_v;
      logic [LOG2N_MAX-1:0] mask_v;
      one_v  = {{(LOG2N_MAX-1){1'b0}}, 1'b1};
      mask_v = (one_v << width) - one_v;
      return ((val << amt) | (val >> (width - amt))) & mask_v;
   endfunction

endpackage

// File: rtl/fft_agu_seq_if.sv
// Control handshake and address buses of the FFT address sequencer.
// Optional feature macro: FFT_AGU_STALL_EN adds the stall input.
interface fft_agu_seq_if #(
   parameter int LOG2N = fft_pkg::LOG2N_DEF
);
   localparam int LW = $clog2(LOG2N + 1);

   logic             start;
`ifdef FFT_AGU_STALL_EN
   logic             stall;
`endif
   logic             busy;
   logic             done;
   logic             rd_valid;
   logic [LOG2N-1:0] rd_a;
   logic [LOG2N-1:0] rd_b;
   logic             rd_bank;
   logic             tw_valid;
   logic [LOG2N-2:0] tw_addr;
   logic             wr_valid;
   logic [LOG2N-1:0] wr_a;
   logic [LOG2N-1:0] wr_b;
   logic             wr_bank;
   logic [LW-1:0]    level;

   modport master (
      input  start,
`ifdef FFT_AGU_STALL_EN
      input  stall,
`endif
      output busy, done, rd_valid, rd_a, rd_b, rd_bank, tw_valid, tw_addr,
             wr_valid, wr_a, wr_b, wr_bank, level
   );

   modport slave (
      output start,
`ifdef FFT_AGU_STALL_EN
      output stall,
`endif
      input  busy, done, rd_valid, rd_a, rd_b, rd_bank, tw_valid, tw_addr,
             wr_valid, wr_a, wr_b, wr_bank, level
   );
endinterface

// File: rtl/fft_delay_pipe.sv
// Fixed-latency valid+data shift register with synchronous clear.
// DEPTH = 0 degenerates to a combinational pass-through.
module fft_delay_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   generate
      if (DEPTH == 0) begin : g_pass
         // Zero latency: forward input straight to output
         always_comb begin
            out_valid = in_valid;
            out_data  = in_data;
         end
      end else begin : g_pipe
         localparam int FLAT = DEPTH * WIDTH;
         logic [DEPTH-1:0] vld_q, vld_d;
         logic [FLAT-1:0]  dat_q, dat_d;

         // Shift one stage per cycle, new entry enters at the bottom
         always_comb begin
            vld_d = (vld_q << 1) | DEPTH'(in_valid);
            dat_d = (dat_q << WIDTH) | FLAT'(in_data);
         end

         // Stage registers; clear drops everything in flight
         always_ff @(posedge clk) begin
            if (clr) begin
               vld_q <= '0;
               dat_q <= '0;
            end else begin
               vld_q <= vld_d;
               dat_q <= dat_d;
            end
         end

         assign out_valid = vld_q[DEPTH-1];
         assign out_data  = dat_q[FLAT-1 -: WIDTH];
      end
   endgenerate
endmodule

// File: rtl/fft_agu_seq.sv
// Address-generation sequencer for an in-place radix-2 FFT of size 2^LOG2N.
// Issues one butterfly read every other cycle, drains between levels so a level
// never reads ahead of the previous level's write-back, and delays matching
// write-back and twiddle addresses through fft_delay_pipe instances.
// Optional feature macro: FFT_AGU_STALL_EN (freezes issue while stall is high).
module fft_agu_seq
   import fft_pkg::*;
#(
   parameter int LOG2N  = LOG2N_DEF,
   parameter int BF_LAT = 3,
   parameter int TW_DLY = 2
) (
   input logic            clk,
   input logic            reset,
   fft_agu_seq_if.master  bus
);
   localparam int AW   = LOG2N;
   localparam int TW_W = LOG2N - 1;
   localparam int HALF = 1 << (LOG2N - 1);
   localparam int LW   = $clog2(LOG2N + 1);
   localparam int CW   = 4;

   agu_state_e      state_q, state_d;
   logic [LW-1:0]   level_q, level_d;
   logic [TW_W-1:0] j_q, j_d;
   logic            phase_q, phase_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            stall_s;
   logic            rd_valid_s;
   logic [AW-1:0]   a_nat_s, b_nat_s;
   logic [AW-1:0]   rd_a_s, rd_b_s;
   logic            rd_bank_s;
   logic [TW_W-1:0] tw_mask_s, tw_addr_s;
   logic [2*AW:0]   wr_in_s, wr_out_s;

`ifdef FFT_AGU_STALL_EN
   assign stall_s = bus.stall;
`else
   assign stall_s = 1'b0;
`endif

   // Sequencer: phase/j stepping within a level, drain and flush counting
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      j_d     = j_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               level_d = '0;
               j_d     = '0;
               phase_d = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (stall_s) begin
               state_d = RUN;
            end else if (phase_q) begin
               phase_d = 1'b0;
            end else if (j_q == TW_W'(HALF - 1)) begin
               j_d     = '0;
               cnt_d   = '0;
               phase_d = 1'b0;
               state_d = (level_q == LW'(LOG2N - 1)) ? FLUSH : DRAIN;
            end else begin
               j_d     = j_q + TW_W'(1);
               phase_d = 1'b1;
            end
         end
         DRAIN: begin
            if (stall_s) begin
               state_d = DRAIN;
            end else if (cnt_q == CW'(BF_LAT - 1)) begin
               state_d = RUN;
               level_d = level_q + LW'(1);
               j_d     = '0;
               phase_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FLUSH: begin
            if (cnt_q == CW'(BF_LAT - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            level_d = '0;
         end
         default: begin
            state_d = IDLE;
            level_d = '0;
            j_d     = '0;
            phase_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         level_q <= '0;
         j_q     <= '0;
         phase_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         j_q     <= j_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rd_valid_s = (state_q == RUN) && !phase_q && !stall_s;
   assign a_nat_s    = {j_q, 1'b0};
   assign b_nat_s    = {j_q, 1'b1};
   assign tw_mask_s  = ~({TW_W{1'b1}} >> level_q);

   // Read and twiddle addresses for butterfly j; zero whenever no read is issued
   always_comb begin
      rd_a_s    = '0;
      rd_b_s    = '0;
      rd_bank_s = 1'b0;
      tw_addr_s = '0;
      if (rd_valid_s) begin
         rd_a_s    = AW'(rotl(LOG2N_MAX'(a_nat_s), 32'(level_q), 32'(LOG2N)));
         rd_b_s    = AW'(rotl(LOG2N_MAX'(b_nat_s), 32'(level_q), 32'(LOG2N)));
         rd_bank_s = level_q[0];
         tw_addr_s = j_q & tw_mask_s;
      end else begin
         rd_bank_s = 1'b0;
      end
   end

   assign wr_in_s = {rd_a_s, rd_b_s, rd_valid_s & ~level_q[0]};

   fft_delay_pipe #(.WIDTH(2 * AW + 1), .DEPTH(BF_LAT)) u_wr_pipe (
      .clk       (clk),
      .clr       (reset),
      .in_valid  (rd_valid_s),
      .in_data   (wr_in_s),
      .out_valid (bus.wr_valid),
      .out_data  (wr_out_s)
   );

   fft_delay_pipe #(.WIDTH(TW_W), .DEPTH(TW_DLY)) u_tw_pipe (
      .clk       (clk),
      .clr       (reset),
      .in_valid  (rd_valid_s),
      .in_data   (tw_addr_s),
      .out_valid (bus.tw_valid),
      .out_data  (bus.tw_addr)
   );

   assign {bus.wr_a, bus.wr_b, bus.wr_bank} = wr_out_s;
   assign bus.rd_valid = rd_valid_s;
   assign bus.rd_a     = rd_a_s;
   assign bus.rd_b     = rd_b_s;
   assign bus.rd_bank  = rd_bank_s;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.level    = level_q;
endmodule

// File: tb/tb_fft_agu_seq.sv
// Scoreboard bench for fft_agu_seq (LOG2N=3, BF_LAT=3, TW_DLY=2).
// Expected read/twiddle/write/done events are planned when a start is issued;
// a negedge monitor compares them against the DUT cycle by cycle.
// Stall scenarios are compiled in only when FFT_AGU_STALL_EN is defined.
module tb_fft_agu_seq;
   localparam int LOG2N  = 3;
   localparam int BF_LAT = 3;
   localparam int TW_DLY = 2;
   localparam int N      = 1 << LOG2N;
   localparam int HALF   = N / 2;
   localparam int T_DONE = LOG2N * (N - 2) + (LOG2N - 1) * (BF_LAT + 1) + BF_LAT + 1;

   typedef struct {
      int cyc;
      int a;
      int b;
      int bank;
      int lvl;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fft_agu_seq_if #(.LOG2N(LOG2N)) bus ();

   fft_agu_seq #(.LOG2N(LOG2N), .BF_LAT(BF_LAT), .TW_DLY(TW_DLY)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ev_t rd_q[$];
   ev_t tw_q[$];
   ev_t wr_q[$];
   int  done_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   int  kill_cyc = -1;
   int  busy_lo = -1;
   int  busy_hi = -2;
   int  last_done_cyc = -1;
   bit  armed = 1'b0;
   bit  stall_at [0:255];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Rotating left by L inside LOG2N bits equals multiplying by 2^L modulo 2^LOG2N-1
   function automatic int rot(input int x, input int L);
      if (x == N - 1) return N - 1;
      return (x << L) % (N - 1);
   endfunction

   // Plan every event of one transform whose cycle 0 is absolute cycle c0
   task automatic plan_run(input int c0);
      int lvl_span, n_steps, idx, rc, a, b, msk, last_rd;
      int step_cyc[$];
      lvl_span = (N - 2) + (BF_LAT + 1);
      n_steps  = (LOG2N - 1) * lvl_span + (N - 2) + 1;
      for (int c = 0; c < 256 && step_cyc.size() < n_steps; c++)
         if (!stall_at[c]) step_cyc.push_back(c);
      last_rd = c0;
      for (int L = 0; L < LOG2N; L++) begin
         msk = ((1 << L) - 1) << (LOG2N - 1 - L);
         for (int j = 0; j < HALF; j++) begin
            idx = L * lvl_span + 2 * j;
            rc  = c0 + step_cyc[idx];
            a   = rot(2 * j, L);
            b   = rot(2 * j + 1, L);
            rd_q.push_back('{rc, a, b, L % 2, L});
            tw_q.push_back('{rc + TW_DLY, j & msk, 0, 0, L});
            wr_q.push_back('{rc + BF_LAT, a, b, 1 - (L % 2), L});
            last_rd = rc;
         end
      end
      done_q.push_back(last_rd + BF_LAT + 1);
      busy_lo = c0;
      busy_hi = last_rd + BF_LAT + 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string name);
      chk(name, 32'({bus.busy, bus.done, bus.rd_valid, bus.rd_a, bus.rd_b, bus.rd_bank,
                     bus.tw_valid, bus.tw_addr, bus.wr_valid, bus.wr_a, bus.wr_b,
                     bus.wr_bank, bus.level}), 32'd0);
   endtask

   // Issue one start and walk the transform; optional extra start and mid-run reset
   task automatic run_one(input int extra_at, input int rst_at, output int c0);
      int run_len;
      bus.start = 1'b1;
      c0 = cyc + 1;
      plan_run(c0);
      run_len = busy_hi - c0 + 3;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < run_len; i++) begin
`ifdef FFT_AGU_STALL_EN
         bus.stall = stall_at[i];
`endif
         bus.start = (i == extra_at);
         if (i == rst_at) begin
            reset    = 1'b1;
            kill_cyc = cyc + 1;
            busy_hi  = cyc;
         end
         tick();
         reset = 1'b0;
         if (i == rst_at) begin
            bus.start = 1'b0;
            @(negedge clk);
            check_quiet("reset_quiet");
            repeat (BF_LAT + 3) tick();
            break;
         end
      end
      bus.start = 1'b0;
`ifdef FFT_AGU_STALL_EN
      bus.stall = 1'b0;
`endif
      for (int c = 0; c < 256; c++) stall_at[c] = 1'b0;
   endtask

   // Monitor: compare every cycle against the front of each expectation queue
   always @(negedge clk) begin : mon
      ev_t ev;
      bit  exp_v;
      if (armed) begin
         if (kill_cyc == cyc) begin
            rd_q.delete();
            tw_q.delete();
            wr_q.delete();
            done_q.delete();
         end
         exp_v = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
         chk("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
         if (exp_v) begin
            ev = rd_q.pop_front();
            if (bus.rd_valid) begin
               chk("rd_a", 32'(bus.rd_a), ev.a);
               chk("rd_b", 32'(bus.rd_b), ev.b);
               chk("rd_bank", 32'(bus.rd_bank), ev.bank);
               chk("level", 32'(bus.level), ev.lvl);
            end
         end
         exp_v = (tw_q.size() > 0) && (tw_q[0].cyc == cyc);
         chk("tw_valid", 32'(bus.tw_valid), 32'(exp_v));
         if (exp_v) begin
            ev = tw_q.pop_front();
            if (bus.tw_valid) chk("tw_addr", 32'(bus.tw_addr), ev.a);
         end
         exp_v = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
         chk("wr_valid", 32'(bus.wr_valid), 32'(exp_v));
         if (exp_v) begin
            ev = wr_q.pop_front();
            if (bus.wr_valid) begin
               chk("wr_a", 32'(bus.wr_a), ev.a);
               chk("wr_b", 32'(bus.wr_b), ev.b);
               chk("wr_bank", 32'(bus.wr_bank), ev.bank);
            end
         end
         exp_v = (done_q.size() > 0) && (done_q[0] == cyc);
         chk("done", 32'(bus.done), 32'(exp_v));
         if (exp_v) void'(done_q.pop_front());
         if (bus.done) last_done_cyc = cyc;
         chk("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      end
   end

   initial begin
      int c0;
      int extra, rst;
      reset     = 1'b1;
      bus.start = 1'b0;
`ifdef FFT_AGU_STALL_EN
      bus.stall = 1'b0;
`endif
      for (int c = 0; c < 256; c++) stall_at[c] = 1'b0;
      repeat (3) tick();
      armed = 1'b1;
      @(negedge clk);
      check_quiet("reset_state");
      tick();
      reset = 1'b0;
      repeat (2) tick();

      // Clean transform with a start pulse during busy at cycle 7
      run_one(7, -1, c0);
      chk("done_cycle", 32'(last_done_cyc - c0), T_DONE);
      repeat (2) tick();

      // Reset at cycle 5 of a run, then a clean transform
      run_one(-1, 5, c0);
      run_one(-1, -1, c0);
      chk("done_after_reset", 32'(last_done_cyc - c0), T_DONE);

`ifdef FFT_AGU_STALL_EN
      // Stall during cycles 2..4 pushes the whole schedule out by 3 cycles
      stall_at[2] = 1'b1;
      stall_at[3] = 1'b1;
      stall_at[4] = 1'b1;
      run_one(-1, -1, c0);
      chk("done_stalled", 32'(last_done_cyc - c0), T_DONE + 3);
`endif

      // Randomized back-to-back transforms
      for (int r = 0; r < 10; r++) begin
         repeat ($urandom_range(0, 3)) tick();
         extra = $urandom_range(1, T_DONE);
         rst   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T_DONE)) : -1;
`ifdef FFT_AGU_STALL_EN
         for (int c = 0; c < 30; c++) stall_at[c] = ($urandom_range(0, 5) == 0);
`endif
         run_one(extra, rst, c0);
      end

      repeat (4) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
